bpsk_demodulator: RTL and testbench

Coherent BPSK symbol detector on the receive side of the BPSK link, consuming one symbol of SAMPLE_NUMBER offset-binary carrier samples per data bit. Each sample is correlated against the sign of the carrier phase: added in the first half-period, subtracted in the second. A hard bit decision, the signed correlation metric and a weak-signal flag are emitted once per symbol. Bit 1 maps to the +sine carrier and bit 0 to the −sine carrier, matching the transmit-side sine generator phase and sample format.

---
 rtl/bpsk_demodulator.sv | 103 ++++++++++
 tb/tb_bpsk_demodulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK symbol detector. Each accepted offset-binary sample is
// centred and folded into a signed correlation accumulator: added while the
// carrier phase index is in the first half-period and subtracted in the
// second. After SAMPLE_NUMBER accepted samples, a hard decision, the signed
// metric and a weak-signal flag are registered and announced for one cycle.
//
// Handshake: sample_valid is a one-way valid with no ready. Every cycle in
// which sample_valid is high consumes sample_in on that rising edge.
// bit_valid is a one-cycle pulse with no backpressure. bit_out, bit_weak and
// metric change only on that pulse and hold their values otherwise.
// There is no FSM. The only sequencing state is phase_cnt, which is exported
// directly, plus the accumulator.
module bpsk_demodulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int THRESHOLD     = 1024,
  localparam int PH_W  = $clog2(SAMPLE_NUMBER),
  localparam int ACC_W = SAMPLE_WIDTH + PH_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    sym_start,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    bit_weak,
  output logic [ACC_W-1:0]        metric,
  output logic [PH_W-1:0]         phase_cnt
);

  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(SAMPLE_NUMBER - 1);
  localparam logic [PH_W-1:0]  HALF_PHASE = PH_W'(SAMPLE_NUMBER / 2);
  // THRESHOLD is assumed to fit in ACC_W bits. Any larger value could never
  // be reached by the metric anyway.
  localparam logic [ACC_W-1:0] THR        = ACC_W'(THRESHOLD);

  logic signed [SAMPLE_WIDTH:0] c_small;
  logic signed [ACC_W-1:0]      c_ext;
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      acc_step;
  logic        [ACC_W-1:0]      step_abs;
  logic                         step_pos;
  logic                         step_weak;

  // Remove the midscale offset. One extra bit holds the full signed range.
  assign c_small = $signed({1'b0, sample_in})
                 - $signed({2'b01, {(SAMPLE_WIDTH-1){1'b0}}});
  assign c_ext   = {{(ACC_W-SAMPLE_WIDTH-1){c_small[SAMPLE_WIDTH]}}, c_small};

  // Correlation step for the current phase, plus the decision terms that
  // apply when this step closes a symbol.
  always_comb begin
    acc_step  = '0;
    step_abs  = '0;
    step_pos  = 1'b0;
    step_weak = 1'b1;
    if (phase_cnt >= HALF_PHASE) acc_step = acc - c_ext;
    else                         acc_step = acc + c_ext;
    // Magnitude cannot overflow: |acc| <= SAMPLE_NUMBER * 2^(SAMPLE_WIDTH-1).
    step_abs  = acc_step[ACC_W-1] ? ACC_W'(-acc_step) : ACC_W'(acc_step);
    // A zero sum is a tie and decides 0.
    step_pos  = !acc_step[ACC_W-1] && (acc_step != '0);
    step_weak = step_abs < THR;
  end

  // Accumulate, realign on sym_start (which wins over symbol end), and
  // register a decision when the last phase of a symbol is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      phase_cnt <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_weak  <= 1'b1;
      metric    <= '0;
    end else begin
      bit_valid <= 1'b0;
      if (sym_start) begin
        if (sample_valid) begin
          acc       <= c_ext;
          phase_cnt <= PH_W'(1);
        end else begin
          acc       <= '0;
          phase_cnt <= '0;
        end
      end else if (sample_valid) begin
        if (phase_cnt == LAST_PHASE) begin
          metric    <= acc_step;
          bit_out   <= step_pos;
          bit_weak  <= step_weak;
          bit_valid <= 1'b1;
          acc       <= '0;
          phase_cnt <= '0;
        end else begin
          acc       <= acc_step;
          phase_cnt <= phase_cnt + PH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Bench for bpsk_demodulator. A driver issues samples and keeps a reference
// model made of a list of the centred samples in the current symbol. When
// the symbol completes, the model pushes the expected decision and its cycle
// stamp into exp_q. A separate monitor pops exp_q on each bit_valid pulse and
// checks that the held outputs match the most recent decision on every cycle.
module tb_bpsk_demodulator;

  localparam int N     = 256;
  localparam int SW    = 12;
  localparam int TH    = 1024;
  localparam int PH_W  = $clog2(N);
  localparam int ACC_W = SW + PH_W + 1;
  localparam int MID   = 2048;
  localparam int EW    = 32 + ACC_W + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SW-1:0]    sample_in = '0;
  logic             sample_valid = 1'b0;
  logic             sym_start = 1'b0;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_weak;
  logic [ACC_W-1:0] metric;
  logic [PH_W-1:0]  phase_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rst_q = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            sym[$];
  int            exp_phase = 0;

  logic             hold_bit = 1'b0;
  logic             hold_weak = 1'b1;
  logic [ACC_W-1:0] hold_metric = '0;

  bpsk_demodulator #(.SAMPLE_NUMBER(N), .SAMPLE_WIDTH(SW), .THRESHOLD(TH)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sym_start(sym_start), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_weak(bit_weak), .metric(metric), .phase_cnt(phase_cnt)
  );

  // Clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference decision: correlate against the sign of the carrier phase.
  task automatic close_symbol();
    int m = 0;
    logic b, w;
    int a;
    for (int i = 0; i < N; i++) m += (i < N / 2) ? sym[i] : -sym[i];
    a = (m < 0) ? -m : m;
    b = (m > 0);
    w = (a < TH);
    exp_q.push_back({32'(cyc + 1), ACC_W'(m), b, w});
    sym.delete();
  endtask

  // Drive one cycle of inputs. Before changing them, check phase_cnt against
  // the model state left by the previous edges.
  task automatic drive(input int s, input logic v, input logic st);
    @(negedge clk);
    chk("phase_cnt", longint'(phase_cnt), longint'(exp_phase));
    sample_in    = SW'(s);
    sample_valid = v;
    sym_start    = st;
    if (st) sym.delete();
    if (v) begin
      sym.push_back(s - MID);
      if (sym.size() == N) close_symbol();
    end
    exp_phase = sym.size();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    sym_start = 1'b0;
    sym.delete();
    exp_phase = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Full symbol with fixed half-period levels and a given gap probability.
  task automatic send_symbol(input int hi, input int lo, input int gap_pct);
    for (int i = 0; i < N; i++) begin
      while ($urandom_range(99) < gap_pct) drive($urandom_range(4095), 1'b0, 1'b0);
      drive((i < N / 2) ? hi : lo, 1'b1, 1'b0);
    end
  endtask

  // Noisy sample of a randomly chosen bit, at a given index in the symbol.
  function automatic int noisy(input logic b, input int idx, input int amp);
    int s;
    s = ((b ^ (idx >= N / 2)) ? amp : -amp) + int'($urandom_range(200)) - 100;
    return MID + s;
  endfunction

  // Monitor: pop on each pulse, then check held outputs on every cycle.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_q) begin
      hold_bit = 1'b0;
      hold_weak = 1'b1;
      hold_metric = '0;
      chk("rst_bit_valid", longint'(bit_valid), 0);
      chk("rst_phase_cnt", longint'(phase_cnt), 0);
    end else if (bit_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", longint'(cyc), longint'(e[EW-1 -: 32]));
        hold_bit = e[1];
        hold_weak = e[0];
        hold_metric = e[ACC_W+1:2];
      end
    end
    chk("bit_out", longint'(bit_out), longint'(hold_bit));
    chk("bit_weak", longint'(bit_weak), longint'(hold_weak));
    chk("metric", longint'($signed(metric)), longint'($signed(hold_metric)));
  end

  // Stimulus
  initial begin
    logic b;
    int amp;
    int cut;
    do_reset();

    // Strong bit 1 followed back-to-back by strong bit 0.
    send_symbol(2148, 1948, 0);
    send_symbol(1948, 2148, 0);

    // Tie and weak symbols.
    send_symbol(2048, 2048, 0);
    send_symbol(2050, 2046, 0);
    send_symbol(2046, 2050, 0);

    // Bit 1 with random gaps.
    send_symbol(2148, 1948, 30);

    // Realign: sym_start with the 100th sample, then 255 more samples.
    for (int i = 0; i < 99; i++) drive((i < N / 2) ? 2148 : 1948, 1'b1, 1'b0);
    drive(2148, 1'b1, 1'b1);
    for (int i = 1; i < N; i++) drive((i < N / 2) ? 2148 : 1948, 1'b1, 1'b0);

    // Reset mid-symbol, then one bit-0 symbol.
    for (int i = 0; i < 130; i++) drive(2148, 1'b1, 1'b0);
    do_reset();
    send_symbol(1948, 2148, 0);

    // Random noisy symbols with gaps.
    for (int k = 0; k < 4; k++) begin
      b = 1'($urandom_range(1));
      amp = $urandom_range(60);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(9) == 0) drive($urandom_range(4095), 1'b0, 1'b0);
        drive(noisy(b, i, amp), 1'b1, 1'b0);
      end
    end

    // Random realign, with or without a sample, then a random full symbol.
    cut = $urandom_range(N - 2, 1);
    for (int i = 0; i < cut; i++) drive($urandom_range(4095), 1'b1, 1'b0);
    drive($urandom_range(4095), 1'($urandom_range(1)), 1'b1);
    for (int i = 0; i < N; i++) drive($urandom_range(4095), 1'b1, 1'b0);

    // Drain pending decisions within a bounded window.
    @(negedge clk);
    sample_valid = 1'b0;
    sym_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("exp_q_drained", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
